// File: rtl/acquisition_burst_ctrl.sv
// acquisition_burst_ctrl
// Run controller for the acquisition sequencer: keeps the sequencer in reset
// while idle, releases it on a trigger for a burst of ADC samples, and
// captures each sample with its sequence index into a first-word
// fall-through FIFO that the MCU drains through register reads.
module acquisition_burst_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm_i,
  input  logic                     trig_i,
  input  logic                     abort_i,
  input  logic [15:0]              p_burst_n_i,
  input  logic                     adc_measure_valid_i,
  input  logic [DATA_W-1:0]        adc_count_i,
  input  logic [2:0]               sample_idx_last_i,
  input  logic                     rd_en_i,
  output logic                     seq_reset_no,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              fifo_data_o,
  output logic                     fifo_empty_o,
  output logic                     fifo_full_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     overflow_o,
  output logic [15:0]              sample_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            seq_reset_n_q, seq_reset_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     sample_cnt_q, sample_cnt_d;
  logic [15:0]     burst_n_q, burst_n_d;
  logic            cap_pend_q, cap_pend_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  logic [31:0]     mem_q [DEPTH];

  logic            clear_s;
  logic            pop_s;
  logic            mem_we_s;
  logic [15:0]     sample_cnt_inc_s;
  logic [31:0]     push_word_s;

  // A capture is one cycle behind the valid pulse: that is when the index
  // from the sequencer has been updated, while the count is still held.
  assign sample_cnt_inc_s = sample_cnt_q + 16'd1;
  assign pop_s            = rd_en_i && !empty_q;

  // Assemble the FIFO word: index on top, count at the bottom, zero between.
  always_comb begin
    push_word_s                = 32'd0;
    push_word_s[DATA_W-1:0]    = adc_count_i;
    push_word_s[31:29]         = sample_idx_last_i;
  end

  // Run-state sequencing: abort beats arm, arm beats trigger.
  always_comb begin
    state_d       = state_q;
    seq_reset_n_d = seq_reset_n_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    burst_n_d     = burst_n_q;
    clear_s       = 1'b0;
    // Valid is only honoured while running; the tail capture may land in IDLE.
    cap_pend_d    = (state_q == ST_RUN) && adc_measure_valid_i;
    if (abort_i) begin
      state_d       = ST_IDLE;
      seq_reset_n_d = 1'b0;
      busy_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d = ST_ARMED;
            clear_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (arm_i) begin
            clear_s = 1'b1;
          end else if (trig_i) begin
            state_d       = ST_RUN;
            seq_reset_n_d = 1'b1;
            busy_d        = 1'b1;
            burst_n_d     = p_burst_n_i;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_RUN: begin
          if (cap_pend_q && (burst_n_q != 16'd0) && (sample_cnt_inc_s == burst_n_q)) begin
            state_d       = ST_IDLE;
            seq_reset_n_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          seq_reset_n_d = 1'b0;
          busy_d        = 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: push/pop pointers, exact occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    sample_cnt_d = sample_cnt_q;
    mem_we_s     = 1'b0;
    if (clear_s) begin
      wr_ptr_d     = {AW{1'b0}};
      rd_ptr_d     = {AW{1'b0}};
      level_d      = {LW{1'b0}};
      overflow_d   = 1'b0;
      sample_cnt_d = 16'd0;
    end else begin
      if (cap_pend_q) begin
        sample_cnt_d = sample_cnt_inc_s;
        // A simultaneous pop frees the slot, so only a full FIFO with no pop drops.
        if (full_q && !pop_s) begin
          overflow_d = 1'b1;
        end else begin
          mem_we_s = 1'b1;
        end
      end else begin
        sample_cnt_d = sample_cnt_q;
      end
      if (mem_we_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({mem_we_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    empty_d = (level_d == LW'(0));
    full_d  = (level_d == LW'(DEPTH));
  end

  // State and status registers; reset returns everything to idle/empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      seq_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      sample_cnt_q  <= 16'd0;
      burst_n_q     <= 16'd0;
      cap_pend_q    <= 1'b0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      level_q       <= {LW{1'b0}};
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_reset_n_q <= seq_reset_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      sample_cnt_q  <= sample_cnt_d;
      burst_n_q     <= burst_n_d;
      cap_pend_q    <= cap_pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
    end
  end

  // Storage array; contents need no reset because empty masks the read.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  assign seq_reset_no = seq_reset_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;
  assign sample_cnt_o = sample_cnt_q;
  assign fifo_empty_o = empty_q;
  assign fifo_full_o  = full_q;
  assign fifo_level_o = level_q;
  assign fifo_data_o  = empty_q ? 32'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_acquisition_burst_ctrl.sv
// Self-checking bench for acquisition_burst_ctrl: a queue-based behavioural
// model predicts every output each cycle, and directed literal checks pin the
// model against hand-computed values.
module tb_acquisition_burst_ctrl;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm_i = 1'b0, trig_i = 1'b0, abort_i = 1'b0, rd_en_i = 1'b0;
  logic [15:0] p_burst_n_i = 16'd0;
  logic        adc_measure_valid_i = 1'b0;
  logic [23:0] adc_count_i = 24'd0;
  logic [2:0]  sample_idx_last_i = 3'd0;
  logic        seq_reset_no, busy_o, done_o, fifo_empty_o, fifo_full_o, overflow_o;
  logic [31:0] fifo_data_o;
  logic [3:0]  fifo_level_o;
  logic [15:0] sample_cnt_o;

  acquisition_burst_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .arm_i(arm_i), .trig_i(trig_i), .abort_i(abort_i),
    .p_burst_n_i(p_burst_n_i), .adc_measure_valid_i(adc_measure_valid_i),
    .adc_count_i(adc_count_i), .sample_idx_last_i(sample_idx_last_i), .rd_en_i(rd_en_i),
    .seq_reset_no(seq_reset_no), .busy_o(busy_o), .done_o(done_o),
    .fifo_data_o(fifo_data_o), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .fifo_level_o(fifo_level_o), .overflow_o(overflow_o), .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 armed, 2 running
  int          m_mode = 0;
  bit          m_started = 1'b0;
  bit          m_seq, m_busy, m_done, m_over, m_pend, m_next_pend, m_finished;
  logic [15:0] m_cnt, m_burst;
  logic [31:0] mq[$];

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_seq = 0; m_busy = 0; m_done = 0; m_over = 0; m_pend = 0;
      m_cnt = 16'd0; m_burst = 16'd0; mq.delete(); m_started = 1'b1;
    end else begin
      m_finished  = 0;
      m_done      = 0;
      m_next_pend = (m_mode == 2) && adc_measure_valid_i;
      if (!abort_i && arm_i && m_mode != 2) begin
        mq.delete(); m_over = 0; m_cnt = 16'd0;
      end else begin
        if (rd_en_i && mq.size() != 0) void'(mq.pop_front());
        if (m_pend) begin
          if (mq.size() < DEPTH) mq.push_back({sample_idx_last_i, 5'd0, adc_count_i});
          else m_over = 1;
          m_cnt = m_cnt + 16'd1;
          m_finished = (m_mode == 2) && (m_burst != 16'd0) && (m_cnt == m_burst);
        end
      end
      if (abort_i) begin
        m_mode = 0; m_seq = 0; m_busy = 0;
      end else if (arm_i && m_mode != 2) begin
        m_mode = 1;
      end else if (trig_i && m_mode == 1) begin
        m_mode = 2; m_seq = 1; m_busy = 1; m_burst = p_burst_n_i;
      end else if (m_finished) begin
        m_mode = 0; m_seq = 0; m_busy = 0; m_done = 1;
      end
      m_pend = m_next_pend;
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("seq_reset_no", {31'd0, seq_reset_no}, {31'd0, m_seq});
      check("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
      check("done_o", {31'd0, done_o}, {31'd0, m_done});
      check("overflow_o", {31'd0, overflow_o}, {31'd0, m_over});
      check("sample_cnt_o", {16'd0, sample_cnt_o}, {16'd0, m_cnt});
      check("fifo_level_o", {28'd0, fifo_level_o}, mq.size());
      check("fifo_empty_o", {31'd0, fifo_empty_o}, {31'd0, mq.size() == 0});
      check("fifo_full_o", {31'd0, fifo_full_o}, {31'd0, mq.size() == DEPTH});
      check("fifo_data_o", fifo_data_o, (mq.size() != 0) ? mq[0] : 32'd0);
      if (done_o === 1'b1) n_done++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Valid pulse, then the index update one cycle later while count is held.
  task automatic sample(input logic [2:0] idx, input logic [23:0] cnt);
    adc_measure_valid_i = 1'b1; adc_count_i = cnt;
    tick();
    adc_measure_valid_i = 1'b0; sample_idx_last_i = idx;
    tick();
  endtask

  task automatic do_arm();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
  endtask

  task automatic do_trig(input logic [15:0] n);
    p_burst_n_i = n; trig_i = 1'b1; tick(); trig_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("rst_seq", {31'd0, seq_reset_no}, 32'd0);
    check("rst_empty", {31'd0, fifo_empty_o}, 32'd1);
    check("rst_data", fifo_data_o, 32'd0);

    // 1: burst of four
    do_arm();
    do_trig(16'd4);
    check("t1_seq_run", {31'd0, seq_reset_no}, 32'd1);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) sample(3'(i % 2), 24'h000100 + 24'(i));
    check("t1_done", {31'd0, done_o}, 32'd1);
    check("t1_seq_end", {31'd0, seq_reset_no}, 32'd0);
    check("t1_level", {28'd0, fifo_level_o}, 32'd4);
    check("t1_head", fifo_data_o, 32'h00000100);
    rd_en_i = 1'b1; tick(); rd_en_i = 1'b0;
    check("t1_done_low", {31'd0, done_o}, 32'd0);
    check("t1_second", fifo_data_o, 32'h20000101);
    check("t1_done_cnt", n_done, 32'd1);

    // 2: burst of ten into an eight-deep FIFO, no reads
    do_arm();
    do_trig(16'd10);
    p_burst_n_i = 16'd3;
    for (int i = 0; i < 8; i++) sample(3'(i), 24'h000200 + 24'(i));
    check("t2_full", {31'd0, fifo_full_o}, 32'd1);
    check("t2_no_ovf", {31'd0, overflow_o}, 32'd0);
    sample(3'd0, 24'h000208);
    check("t2_ovf", {31'd0, overflow_o}, 32'd1);
    sample(3'd1, 24'h000209);
    check("t2_level", {28'd0, fifo_level_o}, 32'd8);
    check("t2_head", fifo_data_o, 32'h00000200);
    check("t2_cnt", {16'd0, sample_cnt_o}, 32'd10);
    rd_en_i = 1'b1; tick(); rd_en_i = 1'b0;
    check("t2_second", fifo_data_o, 32'h20000201);
    check("t2_done_cnt", n_done, 32'd2);
    do_arm();
    check("t2_arm_ovf", {31'd0, overflow_o}, 32'd0);
    check("t2_arm_lvl", {28'd0, fifo_level_o}, 32'd0);

    // 3: push and pop in the same cycle while full
    do_trig(16'd0);
    for (int i = 0; i < 8; i++) sample(3'(i), 24'h000300 + 24'(i));
    adc_measure_valid_i = 1'b1; adc_count_i = 24'h000308;
    tick();
    adc_measure_valid_i = 1'b0; sample_idx_last_i = 3'd0; rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("t3_level", {28'd0, fifo_level_o}, 32'd8);
    check("t3_ovf", {31'd0, overflow_o}, 32'd0);
    check("t3_head", fifo_data_o, 32'h20000301);
    abort_i = 1'b1; tick(); abort_i = 1'b0;

    // 4: continuous burst with reads, then abort
    do_arm();
    do_trig(16'd0);
    rd_en_i = 1'b1;
    for (int i = 0; i < 19; i++) sample(3'(i), 24'h000400 + 24'(i));
    adc_measure_valid_i = 1'b1; adc_count_i = 24'h000413;
    tick();
    adc_measure_valid_i = 1'b0; sample_idx_last_i = 3'd3; rd_en_i = 1'b0;
    tick();
    check("t4_busy", {31'd0, busy_o}, 32'd1);
    check("t4_cnt", {16'd0, sample_cnt_o}, 32'd20);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("t4_seq", {31'd0, seq_reset_no}, 32'd0);
    check("t4_level", {28'd0, fifo_level_o}, 32'd1);
    check("t4_last", fifo_data_o, 32'h60000413);
    tick();
    check("t4_done_cnt", n_done, 32'd2);

    // 5: trigger gating
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    check("t5_idle_trig", {31'd0, seq_reset_no}, 32'd0);
    arm_i = 1'b1; trig_i = 1'b1; tick(); arm_i = 1'b0; trig_i = 1'b0;
    check("t5_arm_wins", {31'd0, seq_reset_no}, 32'd0);
    do_trig(16'd5);
    check("t5_run", {31'd0, seq_reset_no}, 32'd1);

    // 6: reset mid-burst
    sample(3'd0, 24'h000500);
    sample(3'd1, 24'h000501);
    check("t6_pre_lvl", {28'd0, fifo_level_o}, 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_seq", {31'd0, seq_reset_no}, 32'd0);
    check("t6_empty", {31'd0, fifo_empty_o}, 32'd1);
    check("t6_cnt", {16'd0, sample_cnt_o}, 32'd0);
    tick(); tick(); tick();
    check("t6_done_cnt", n_done, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
